ghash_tag_serializer: RTL and testbench

- Reader-side counterpart of the 128-bit GHASH S/tag register.
- Accepts one completed WIDTH-bit tag/S value on a load handshake and streams it out as WORD_W-bit words, MSB-first, over a valid/ready interface.
- Supports truncated GCM tags through a per-tag word count.
- Sits between the GHASH/tag stage and the narrow output bus.

---
 rtl/ghash_tag_serializer.sv | 118 +++++++++++
 tb/tb_ghash_tag_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_tag_serializer.sv
// rtl/ghash_tag_serializer.sv - serializes one WIDTH-bit GHASH tag/S value into MSB-first WORD_W-bit words
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   tag presented for load
//   in_ready   idle and able to load
//   in_data    tag/S value, bit WIDTH-1 leaves first
//   len_words  words to emit for this tag (0 or >NWORDS means all), sampled at load
//   flush      synchronous abort of the current tag
//   out_valid  out_data holds a valid word
//   out_ready  sink accepts the word
//   out_data   current word, zero when out_valid is low
//   out_last   current word is the final word of the tag
//   busy       a tag is being sent
module ghash_tag_serializer #(
  parameter int WIDTH  = 128,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CNT_W-1:0]  len_words,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int              NWORDS   = WIDTH / WORD_W;
  localparam logic [CNT_W-1:0] NWORDS_C = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_eff_len;
  logic               w_last;

  // A zero or oversized request means "send the whole tag".
  assign w_eff_len = ((len_words == '0) || (len_words > NWORDS_C)) ? NWORDS_C : len_words;
  assign w_last    = (r_cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;
    out_data    = '0;

    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        // flush wins over a load even though in_ready reads high.
        if (in_valid && !flush) begin
          w_state_nxt = S_SEND;
          w_shreg_nxt = in_data;
          w_cnt_nxt   = w_eff_len;
        end
      end

      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_shreg[WIDTH-1 -: WORD_W];
        out_last  = w_last;
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_shreg_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (out_ready) begin
          if (w_last) begin
            // Clear so truncated-tag residue never lingers in the register.
            w_state_nxt = S_IDLE;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_shreg_nxt = r_shreg << WORD_W;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ghash_tag_serializer.sv
// tb/tb_ghash_tag_serializer.sv - randomized self-checking bench for ghash_tag_serializer
module tb_ghash_tag_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [2:0]   len_words;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_w[$];
  logic        obs_l[$];
  int          hold_bad;
  int          ncyc;
  bit          timeout;

  localparam logic [127:0] TAG_FIX = 128'h0123456789ABCDEF_FEDCBA9876543210;

  always #5 clk = ~clk;

  ghash_tag_serializer #(.WIDTH(128), .WORD_W(32), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .len_words (len_words),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Reference: the first L 32-bit slices of the tag, most significant first.
  task automatic model(input logic [127:0] d, input int len);
    int l;
    logic [127:0] v;
    l = (len == 0 || len > 4) ? 4 : len;
    exp_q.delete();
    for (int i = 0; i < l; i++) begin
      v = d >> (96 - 32 * i);
      exp_q.push_back(v[31:0]);
    end
  endtask

  task automatic clear_obs();
    obs_w.delete();
    obs_l.delete();
  endtask

  // Called at a negedge; presents a tag and returns at the next negedge.
  task automatic do_load(input logic [127:0] d, input logic [2:0] len, input bit hold_valid);
    in_valid  = 1'b1;
    in_data   = d;
    len_words = len;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  // Collects accepted words until out_valid drops; records stall-hold violations.
  task automatic stream(input int pct, input int stall_at, input int stall_n);
    int          guard;
    int          stalls;
    int          acc;
    bit          r;
    bit          prev_stall;
    logic [31:0] pd;
    logic        pl;
    guard = 0; stalls = stall_n; acc = 0; prev_stall = 0;
    pd = '0; pl = 1'b0;
    hold_bad = 0; ncyc = 0; timeout = 0;
    while (out_valid === 1'b1) begin
      if (guard >= 200) begin
        timeout = 1;
        break;
      end
      if (prev_stall && (out_data !== pd || out_last !== pl)) hold_bad++;
      if (acc == stall_at && stalls > 0) begin
        r = 0;
        stalls--;
      end else begin
        r = ($urandom_range(0, 99) < pct);
      end
      out_ready  = r;
      pd         = out_data;
      pl         = out_last;
      prev_stall = !r;
      @(negedge clk);
      guard++;
      ncyc++;
      if (r) begin
        obs_w.push_back(pd);
        obs_l.push_back(pl);
        acc++;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; len_words = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_and_truncated();
    logic [2:0] lens [4];
    lens[0] = 3'd4; lens[1] = 3'd3; lens[2] = 3'd0; lens[3] = 3'd7;
    for (int t = 0; t < 4; t++) begin
      model(TAG_FIX, int'(lens[t]));
      clear_obs();
      do_load(TAG_FIX, lens[t], 1'b0);
      stream(100, -1, 0);
      total++; if (ncyc !== exp_q.size()) begin bad++; $display("FAIL len%0d_cycles got=%0d exp=%0d", lens[t], ncyc, exp_q.size()); end
      total++; if (obs_w.size() !== exp_q.size()) begin bad++; $display("FAIL len%0d_count got=%0d exp=%0d", lens[t], obs_w.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_w.size(); i++) begin
        total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL len%0d_word%0d got=%h exp=%h", lens[t], i, obs_w[i], exp_q[i]); end
        total++; if (obs_l[i] !== 1'(i == exp_q.size() - 1)) begin bad++; $display("FAIL len%0d_last%0d got=%b exp=%b", lens[t], i, obs_l[i], i == exp_q.size() - 1); end
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL len%0d_in_ready_after got=%b exp=1", lens[t], in_ready); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL len%0d_data_masked got=%h exp=0", lens[t], out_data); end
    end
  endtask

  task automatic test_backpressure();
    model(TAG_FIX, 4);
    clear_obs();
    do_load(TAG_FIX, 3'd4, 1'b1);
    in_data   = ~TAG_FIX;
    len_words = 3'd1;
    out_ready = 1'b1;
    obs_w.push_back(out_data);
    obs_l.push_back(out_last);
    @(negedge clk);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      total++; if (out_data !== 32'h89ABCDEF) begin bad++; $display("FAIL stall%0d_data got=%h exp=89abcdef", s, out_data); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL stall%0d_last got=%b exp=0", s, out_last); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall%0d_in_ready got=%b exp=0", s, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    stream(100, -1, 0);
    total++; if (obs_w.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", obs_w.size()); end
    for (int i = 0; i < 4 && i < obs_w.size(); i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, obs_w[i], exp_q[i]); end
      total++; if (obs_l[i] !== 1'(i == 3)) begin bad++; $display("FAIL bp_last%0d got=%b exp=%b", i, obs_l[i], i == 3); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    logic [2:0]   lb;
    a  = {$urandom, $urandom, $urandom, $urandom};
    b  = {$urandom, $urandom, $urandom, $urandom};
    lb = 3'($urandom_range(1, 3));
    model(a, 4);
    clear_obs();
    do_load(a, 3'd4, 1'b1);
    in_data   = b;
    len_words = lb;
    stream(100, -1, 0);
    total++; if (obs_w.size() !== 4) begin bad++; $display("FAIL b2b_a_count got=%0d exp=4", obs_w.size()); end
    for (int i = 0; i < 4 && i < obs_w.size(); i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_a_word%0d got=%h exp=%h", i, obs_w[i], exp_q[i]); end
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_load got=%b exp=1", out_valid); end
    model(b, int'(lb));
    clear_obs();
    stream(100, -1, 0);
    total++; if (obs_w.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_b_count got=%0d exp=%0d", obs_w.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_w.size(); i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_b_word%0d got=%h exp=%h", i, obs_w[i], exp_q[i]); end
    end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL b2b_residual got=%h exp=0", out_data); end
  endtask

  task automatic test_flush();
    do_load(TAG_FIX, 3'd4, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_data !== 32'h89ABCDEF) begin bad++; $display("FAIL flush_word2 got=%h exp=89abcdef", out_data); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL flush_out_data got=%h exp=0", out_data); end
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_out_valid got=%b exp=0", out_valid); end
    model(TAG_FIX, 2);
    clear_obs();
    do_load(TAG_FIX, 3'd2, 1'b0);
    stream(100, -1, 0);
    total++; if (obs_w.size() !== 2) begin bad++; $display("FAIL flush_after_count got=%0d exp=2", obs_w.size()); end
    for (int i = 0; i < 2 && i < obs_w.size(); i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL flush_after_word%0d got=%h exp=%h", i, obs_w[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] d;
    do_load(TAG_FIX, 3'd4, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_data !== 32'hFEDCBA98) begin bad++; $display("FAIL arst_word3 got=%h exp=fedcba98", out_data); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL arst_out_data got=%h exp=0", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_release_out_valid got=%b exp=0", out_valid); end
    d = {$urandom, $urandom, $urandom, $urandom};
    model(d, 4);
    clear_obs();
    do_load(d, 3'd4, 1'b0);
    stream(100, -1, 0);
    total++; if (obs_w.size() !== 4) begin bad++; $display("FAIL arst_after_count got=%0d exp=4", obs_w.size()); end
    for (int i = 0; i < 4 && i < obs_w.size(); i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL arst_after_word%0d got=%h exp=%h", i, obs_w[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [127:0] d;
    logic [2:0]   len;
    for (int it = 0; it < 25; it++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      len = 3'($urandom_range(0, 7));
      model(d, int'(len));
      clear_obs();
      do_load(d, len, 1'b0);
      stream($urandom_range(20, 100), $urandom_range(0, 3), $urandom_range(0, 4));
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rnd%0d_timeout got=%b exp=0", it, timeout); end
      total++; if (hold_bad !== 0) begin bad++; $display("FAIL rnd%0d_hold got=%0d exp=0", it, hold_bad); end
      total++; if (obs_w.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, obs_w.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_w.size(); i++) begin
        total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_word%0d got=%h exp=%h", it, i, obs_w[i], exp_q[i]); end
        total++; if (obs_l[i] !== 1'(i == exp_q.size() - 1)) begin bad++; $display("FAIL rnd%0d_last%0d got=%b exp=%b", it, i, obs_l[i], i == exp_q.size() - 1); end
      end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rnd%0d_masked got=%h exp=0", it, out_data); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_and_truncated();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
